// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel-load and serial-stream signals of the PISO serializer
// master drives the word and shift enable; slave is the serializer itself.
interface piso_serializer_if #(
  parameter int DW = 4
);
  logic          start;
  logic [DW-1:0] inp;
  logic          enb;
  logic          ready;
  logic          busy;
  logic          ser_valid;
  logic          ser_out;
  logic          done;

  modport master (
    output start, inp, enb,
    input  ready, busy, ser_valid, ser_out, done
  );

  modport slave (
    input  start, inp, enb,
    output ready, busy, ser_valid, ser_out, done
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with ready/start load
// Shifts a DW-bit word out one bit per enabled cycle, MSB or LSB first.
module piso_serializer #(
  parameter int DW        = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst,
  piso_serializer_if.slave    bus
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          done_q,  done_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          shreg_d = bus.inp;
          cnt_d   = CW'(DW);
        end
      end
      SHIFT: begin
        if (bus.enb) begin
          // Shift toward the output end so the next pending bit is always at the same position.
          if (MSB_FIRST != 0) shreg_d = {shreg_q[DW-2:0], 1'b0};
          else                shreg_d = {1'b0, shreg_q[DW-1:1]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.busy      = bus.ser_valid;
  assign bus.ser_out   = bus.ser_valid &
                         ((MSB_FIRST != 0) ? shreg_q[DW-1] : shreg_q[0]);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
// Instance a is MSB-first, instance b is LSB-first; both DW=4.
module tb_piso_serializer;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.DW(4)) bus_a ();
  piso_serializer_if #(.DW(4)) bus_b ();

  piso_serializer #(.DW(4), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  piso_serializer #(.DW(4), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_a(input string tag, input logic so, input logic sv, input logic rdy, input logic dn);
    check({tag, ".ser_out"},   32'(bus_a.ser_out),   32'(so));
    check({tag, ".ser_valid"}, 32'(bus_a.ser_valid), 32'(sv));
    check({tag, ".busy"},      32'(bus_a.busy),      32'(sv));
    check({tag, ".ready"},     32'(bus_a.ready),     32'(rdy));
    check({tag, ".done"},      32'(bus_a.done),      32'(dn));
  endtask

  task automatic cyc_b(input string tag, input logic so, input logic sv, input logic rdy, input logic dn);
    check({tag, ".ser_out"},   32'(bus_b.ser_out),   32'(so));
    check({tag, ".ser_valid"}, 32'(bus_b.ser_valid), 32'(sv));
    check({tag, ".busy"},      32'(bus_b.busy),      32'(sv));
    check({tag, ".ready"},     32'(bus_b.ready),     32'(rdy));
    check({tag, ".done"},      32'(bus_b.done),      32'(dn));
  endtask

  logic [3:0] exp_bits;
  logic [5:0] enb_pat;
  logic [5:0] lsb_so;

  initial begin
    rst = 1'b0;
    bus_a.start = 1'b1; bus_a.inp = 4'hF; bus_a.enb = 1'b1;
    bus_b.start = 1'b1; bus_b.inp = 4'hF; bus_b.enb = 1'b1;

    // reset with start/enb asserted
    step();
    cyc_a("rst_c1_a", 0, 0, 1, 0);
    cyc_b("rst_c1_b", 0, 0, 1, 0);
    step();
    cyc_a("rst_c2_a", 0, 0, 1, 0);
    cyc_b("rst_c2_b", 0, 0, 1, 0);
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0; bus_b.enb = 1'b0;
    step();
    cyc_a("idle_a", 0, 0, 1, 0);

    // MSB-first 4'hA
    exp_bits = 4'b1010;
    bus_a.inp = 4'hA; bus_a.start = 1'b1; bus_a.enb = 1'b1;
    step();
    bus_a.start = 1'b0; bus_a.inp = 4'h0;
    for (int k = 0; k < 4; k++) begin
      cyc_a($sformatf("msb_c%0d", k + 1), exp_bits[3-k], 1, 0, 0);
      step();
    end
    cyc_a("msb_c5", 0, 0, 1, 1);
    step();
    cyc_a("msb_c6", 0, 0, 1, 0);

    // LSB-first 4'h3 with enb gaps
    enb_pat = 6'b111001;
    lsb_so  = 6'b001111;
    bus_b.inp = 4'h3; bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus_b.enb = enb_pat[c];
      cyc_b($sformatf("lsb_c%0d", c + 1), lsb_so[c], 1, 0, 0);
      step();
    end
    bus_b.enb = 1'b0;
    cyc_b("lsb_c7", 0, 0, 1, 1);
    step();
    cyc_b("lsb_c8", 0, 0, 1, 0);

    // start while busy: 4'hC, attempted overwrite with 4'h5
    exp_bits = 4'b1100;
    bus_a.inp = 4'hC; bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin bus_a.start = 1'b1; bus_a.inp = 4'h5; end
      else        begin bus_a.start = 1'b0; end
      cyc_a($sformatf("busy_c%0d", k + 1), exp_bits[3-k], 1, 0, 0);
      step();
    end
    bus_a.start = 1'b0;
    cyc_a("busy_c5", 0, 0, 1, 1);
    step();

    // back-to-back 4'h9 then 4'h6 started in the done cycle
    exp_bits = 4'b1001;
    bus_a.inp = 4'h9; bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc_a($sformatf("b2b_c%0d", k + 1), exp_bits[3-k], 1, 0, 0);
      step();
    end
    cyc_a("b2b_c5", 0, 0, 1, 1);
    bus_a.inp = 4'h6; bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    exp_bits = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      cyc_a($sformatf("b2b_c%0d", k + 6), exp_bits[3-k], 1, 0, 0);
      step();
    end
    cyc_a("b2b_c10", 0, 0, 1, 1);
    step();

    // reset mid-frame, then reload 4'h1
    bus_a.inp = 4'hF; bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    cyc_a("mrst_c1", 1, 1, 0, 0);
    step();
    cyc_a("mrst_c2", 1, 1, 0, 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    cyc_a("mrst_c3", 0, 0, 1, 0);
    exp_bits = 4'b0001;
    bus_a.inp = 4'h1; bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc_a($sformatf("mrst_c%0d", k + 4), exp_bits[3-k], 1, 0, 0);
      step();
    end
    cyc_a("mrst_c8", 0, 0, 1, 1);
    step();
    cyc_a("mrst_c9", 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that accepts a DW-bit word through a ready/start handshake and shifts it out one bit per enabled cycle, with the direction selected by a parameter. It is the transmit-side counterpart of the team's parallel and serial-in registers: a serial stream it produces can be rebuilt into the original word by a SIPO capture register that uses the same bit order. It sits between a parallel data source and any single-wire or bit-serial link.

## Interface
- DW, 4: word width in bits; legal range DW >= 2.
- MSB_FIRST, 1: when 1, bit DW-1 is sent first; when 0, bit 0 is sent first.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset; sampled on clk only.
- start  input  1  load request; a word is accepted on an edge where start=1 and ready=1.
- inp  input  DW  parallel word; captured on the accepting edge.
- enb  input  1  shift enable; consumes the currently presented bit.
- ready  output  1  block is idle and can accept a word.
- busy  output  1  a frame is in progress; equals ser_valid.
- ser_valid  output  1  ser_out carries a frame bit.
- ser_out  output  1  current serial bit; 0 when ser_valid=0.
- done  output  1  one-cycle pulse after the last bit is consumed.

## Operation
- All outputs are registered or decoded from registered state only; there is no combinational path from an input to an output.
- State machine:
  - IDLE: ready=1, ser_valid=0, ser_out=0.
  - SHIFT: ready=0, ser_valid=1.
- IDLE -> SHIFT on start=1:
  - the shift register loads inp;
  - the bit counter loads DW.
- In IDLE:
  - enb is ignored;
  - start=0 holds the state.
- In SHIFT, ser_out presents the first pending bit:
  - MSB_FIRST=1: shift register bit DW-1.
  - MSB_FIRST=0: shift register bit 0.
- In SHIFT with enb=1:
  - the register shifts by one position toward the output end (left when MSB_FIRST=1, right when MSB_FIRST=0), filling with 0;
  - the counter decrements.
- In SHIFT with enb=0: the register, the counter and ser_out all hold. Gaps of any length are allowed.
- SHIFT -> IDLE on an edge where enb=1 and counter=1. done=1 for exactly the following cycle.
- start is ignored while in SHIFT. The word in flight is never corrupted, and inp changes have no effect.
- The counter is $clog2(DW+1) bits wide and never wraps. Counter=0 only occurs in IDLE.
- Reset is sampled on an edge with rst=0, in any state including mid-frame. From the next cycle:
  - state=IDLE, shift register=0, counter=0;
  - ready=1, busy=0, ser_valid=0, ser_out=0, done=0.
  - start and enb are ignored on that edge.

## Timing
- Label the cycle following the accepting edge as cycle 1.
- With enb held at 1:
  - bit k of the frame (k=0 is the first bit sent) is on ser_out in cycle k+1, so bits occupy cycles 1..DW;
  - done=1 and ready=1 in cycle DW+1.
- start=1 in cycle DW+1 is accepted. The next frame's first bit appears in cycle DW+2.
- Minimum frame period is therefore DW+1 cycles, including one idle cycle.
- A bit is consumed on the edge that ends a cycle in which both ser_valid=1 and enb=1.
- With enb gaps, the frame stretches by exactly the number of cycles with enb=0. done still follows the last consuming edge by one cycle.
- done is never asserted in two consecutive cycles.
- Latency from the accepting edge to the first valid bit: 1 cycle.

## Test plan
- Reset values: hold rst=0 for 2 edges with start=1 and enb=1 -> ready=1, busy=0, ser_valid=0, ser_out=0, done=0 in both cycles.
- MSB-first frame: DW=4, MSB_FIRST=1, inp=4'hA, start pulse, enb=1 -> ser_out=1,0,1,0 in cycles 1-4, done=1 only in cycle 5.
- LSB-first frame with gaps: DW=4, MSB_FIRST=0, inp=4'h3, enb pattern 1,0,0,1,1,1 -> ser_out=1,1,1,1,0,0 in cycles 1-6, done=1 in cycle 7.
- Start while busy: load 4'hC, then assert start with inp=4'h5 in cycle 2 -> stream stays 1,1,0,0 and ready=0 until cycle 5.
- Back-to-back frames: load 4'h9, then start with 4'h6 in cycle 5 (the done cycle) -> 1,0,0,1 in cycles 1-4, then 0,1,1,0 in cycles 6-9, done in cycles 5 and 10.
- Reset mid-frame: load 4'hF, apply rst=0 on the edge ending cycle 2 -> cycle 3 shows ser_valid=0, ready=1, done=0; a subsequent load of 4'h1 (MSB_FIRST=1) yields 0,0,0,1.
